// File: rtl/paint_cursor_ctrl.sv
// Paint control unit: cursor movement on a step tick, square-brush painting
// into VRAM one pixel per clock, erase colour, and full-canvas clear sweep.
module paint_cursor_ctrl #(
    parameter int          X_W      = 8,
    parameter int          Y_W      = 8,
    parameter int          X_MAX    = 255,
    parameter int          Y_MAX    = 255,
    parameter int          X_INIT   = 128,
    parameter int          Y_INIT   = 128,
    parameter int          TICK_DIV = 2097152,
    parameter logic [11:0] BG_COLOR = 12'hFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        rgb,
    input  logic [3:0]         dirc,
    input  logic               draw,
    input  logic               erase,
    input  logic [1:0]         brush,
    input  logic               clear,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               we,
    output logic [X_W+Y_W-1:0] waddr,
    output logic [11:0]        wdata,
    output logic               busy
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(Y_MAX);
    localparam logic [X_W:0]     PX_LIM   = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]     PY_LIM   = (Y_W+1)'(Y_MAX);

    typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [X_W-1:0]       x_q, x_d, ox_q, ox_d, cx_q, cx_d;
    logic [Y_W-1:0]       y_q, y_d, oy_q, oy_d, cy_q, cy_d;
    logic [1:0]           dx_q, dx_d, dy_q, dy_d, smax_q, smax_d;
    logic [11:0]          color_q, color_d, wdata_q, wdata_d;
    logic [X_W+Y_W-1:0]   waddr_q, waddr_d;
    logic                 we_q, we_d, busy_q, busy_d;

    logic                 tick, paint_last, clear_last;
    logic [X_W-1:0]       nx;
    logic [Y_W-1:0]       ny;
    logic [X_W:0]         px;
    logic [Y_W:0]         py;

    assign tick       = (cnt_q == CNT_LAST);
    assign paint_last = (dx_q == smax_q) && (dy_q == smax_q);
    assign clear_last = (cx_q == X_LAST) && (cy_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= X_W'(X_INIT);
            y_q     <= Y_W'(Y_INIT);
            ox_q    <= '0;
            oy_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            smax_q  <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            smax_q  <= smax_d;
            color_q <= color_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (clear)              state_d = S_CLEAR;
                else if (tick && draw)  state_d = S_PAINT;
            end
            S_PAINT: if (paint_last) state_d = S_IDLE;
            S_CLEAR: if (clear_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        x_d     = x_q;
        y_d     = y_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        smax_d  = smax_q;
        color_d = color_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        nx = x_q;
        if (dirc[1] && !dirc[3] && x_q != '0)          nx = x_q - X_W'(1);
        else if (dirc[3] && !dirc[1] && x_q < X_LAST)  nx = x_q + X_W'(1);
        ny = y_q;
        if (dirc[0] && !dirc[2] && y_q != '0)          ny = y_q - Y_W'(1);
        else if (dirc[2] && !dirc[0] && y_q < Y_LAST)  ny = y_q + Y_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    cx_d = '0;
                    cy_d = '0;
                end else if (tick) begin
                    x_d = nx;
                    y_d = ny;
                    if (draw) begin
                        ox_d    = nx;
                        oy_d    = ny;
                        dx_d    = '0;
                        dy_d    = '0;
                        smax_d  = brush;
                        color_d = erase ? BG_COLOR : rgb;
                    end
                end
            end
            S_PAINT: begin
                if (!paint_last) begin
                    if (dx_q == smax_q) begin
                        dx_d = '0;
                        dy_d = dy_q + 2'd1;
                    end else begin
                        dx_d = dx_q + 2'd1;
                    end
                end
            end
            S_CLEAR: begin
                if (!clear_last) begin
                    if (cy_q == Y_LAST) begin
                        cy_d = '0;
                        cx_d = cx_q + X_W'(1);
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // Write port is registered one slot ahead: it is driven from the
        // slot the state machine moves into, so the first write lands in
        // the cycle right after the tick (or clear request).
        px = {1'b0, ox_d} + (X_W+1)'(dx_d);
        py = {1'b0, oy_d} + (Y_W+1)'(dy_d);
        if (state_d == S_PAINT) begin
            if (px <= PX_LIM && py <= PY_LIM) begin
                we_d    = 1'b1;
                waddr_d = {px[X_W-1:0], py[Y_W-1:0]};
                wdata_d = color_d;
            end
        end else if (state_d == S_CLEAR) begin
            we_d    = 1'b1;
            waddr_d = {cx_d, cy_d};
            wdata_d = BG_COLOR;
        end
        busy_d = (state_d != S_IDLE);
    end

    assign x     = x_q;
    assign y     = y_q;
    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_paint_cursor_ctrl.sv
// Scoreboard bench for paint_cursor_ctrl: two instances (X_MAX=255 and 254)
// share stimulus; expected VRAM writes are queued per instance.
module tb_paint_cursor_ctrl;

    localparam int TD = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] rgb;
    logic [3:0]  dirc;
    logic        draw, erase, clear;
    logic [1:0]  brush;

    logic [7:0]  x0, y0, x1, y1;
    logic        we0, we1, busy0, busy1;
    logic [15:0] waddr0, waddr1;
    logic [11:0] wdata0, wdata1;

    always #5 clk = ~clk;

    paint_cursor_ctrl #(.TICK_DIV(TD)) u_dut0 (
        .clk(clk), .rst(rst), .rgb(rgb), .dirc(dirc), .draw(draw), .erase(erase),
        .brush(brush), .clear(clear), .x(x0), .y(y0), .we(we0), .waddr(waddr0),
        .wdata(wdata0), .busy(busy0)
    );

    paint_cursor_ctrl #(.TICK_DIV(TD), .X_MAX(254)) u_dut1 (
        .clk(clk), .rst(rst), .rgb(rgb), .dirc(dirc), .draw(draw), .erase(erase),
        .brush(brush), .clear(clear), .x(x1), .y(y1), .we(we1), .waddr(waddr1),
        .wdata(wdata1), .busy(busy1)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    logic [27:0] q0[$];
    logic [27:0] q1[$];
    int          ex[2];
    int          ey[2];
    int          xmax[2] = '{255, 254};
    int          tcnt;

    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= (tcnt == TD-1) ? 0 : tcnt + 1;
    end

    function automatic logic [27:0] pk(input int px, input int py, input logic [11:0] c);
        logic [7:0] ax, ay;
        ax = 8'(px);
        ay = 8'(py);
        return {ax, ay, c};
    endfunction

    always @(negedge clk) begin
        logic [27:0] e;
        if (we0 === 1'b1) begin
            if (q0.size() == 0) check("dut0_spurious_we", 32'(we0), 32'd0);
            else begin
                e = q0.pop_front();
                check("dut0_write", 32'({waddr0, wdata0}), 32'(e));
            end
        end
        if (we1 === 1'b1) begin
            if (q1.size() == 0) check("dut1_spurious_we", 32'(we1), 32'd0);
            else begin
                e = q1.pop_front();
                check("dut1_write", 32'({waddr1, wdata1}), 32'(e));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_tick_cycle();
        for (int i = 0; i < 2*TD; i++) begin
            @(negedge clk);
            if (tcnt == TD-1) return;
        end
    endtask

    task automatic check_reset_state();
        check("rst_we0",   32'(we0),   32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_x0",    32'(x0),    32'd128);
        check("rst_y0",    32'(y0),    32'd128);
        check("rst_we1",   32'(we1),   32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        for (int i = 0; i < 2; i++) begin
            ex[i] = 128;
            ey[i] = 128;
        end
    endtask

    // One step tick with the given controls; abort_slot>0 resets the DUTs
    // during that paint slot (slots before it are still written).
    task automatic step(input logic [3:0] d, input logic dr, input logic er,
                        input logic [1:0] br, input logic [11:0] col, input int abort_slot);
        int sz, slot, b0, b1;
        logic [11:0] c;
        wait_tick_cycle();
        dirc = d; draw = dr; erase = er; brush = br; rgb = col;
        sz = int'(br) + 1;
        c  = er ? 12'hFFF : col;
        for (int i = 0; i < 2; i++) begin
            if (d[1] && !d[3] && ex[i] > 0)            ex[i]--;
            else if (d[3] && !d[1] && ex[i] < xmax[i]) ex[i]++;
            if (d[0] && !d[2] && ey[i] > 0)            ey[i]--;
            else if (d[2] && !d[0] && ey[i] < 255)     ey[i]++;
            if (dr) begin
                slot = 0;
                for (int yy = 0; yy < sz; yy++)
                    for (int xx = 0; xx < sz; xx++) begin
                        if ((abort_slot == 0 || slot < abort_slot) &&
                            ex[i] + xx <= xmax[i] && ey[i] + yy <= 255) begin
                            if (i == 0) q0.push_back(pk(ex[i] + xx, ey[i] + yy, c));
                            else        q1.push_back(pk(ex[i] + xx, ey[i] + yy, c));
                        end
                        slot++;
                    end
            end
        end
        @(posedge clk);
        #1;
        draw = 1'b0; dirc = '0;
        rgb = 12'($urandom); erase = 1'($urandom); brush = 2'($urandom);
        check("move_x0", 32'(x0), 32'(ex[0]));
        check("move_y0", 32'(y0), 32'(ey[0]));
        check("move_x1", 32'(x1), 32'(ex[1]));
        check("move_y1", 32'(y1), 32'(ey[1]));
        if (!dr) begin
            check("idle_busy0", 32'(busy0), 32'd0);
            check("idle_we0",   32'(we0),   32'd0);
        end else begin
            check("first_we0", 32'(we0), 32'd1);
            check("first_we1", 32'(we1), 32'd1);
            if (abort_slot != 0) begin
                repeat (abort_slot - 1) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                check_reset_state();
                repeat (3*TD) @(posedge clk);
            end else begin
                b0 = 0; b1 = 0;
                for (int k = 0; k < 40; k++) begin
                    if (busy0 !== 1'b1 && busy1 !== 1'b1) break;
                    b0 += int'(busy0);
                    b1 += int'(busy1);
                    @(posedge clk);
                    #1;
                end
                check("paint_len0", 32'(b0), 32'(sz*sz));
                check("paint_len1", 32'(b1), 32'(sz*sz));
            end
        end
    endtask

    task automatic move(input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 2'd0, 12'h000, 0);
    endtask

    task automatic do_clear(input int abort_at);
        int idx, b0, b1;
        wait_tick_cycle();
        clear = 1'b1;
        dirc  = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            idx = 0;
            for (int px = 0; px <= xmax[i]; px++)
                for (int py = 0; py <= 255; py++) begin
                    if (abort_at == 0 || idx < abort_at) begin
                        if (i == 0) q0.push_back(pk(px, py, 12'hFFF));
                        else        q1.push_back(pk(px, py, 12'hFFF));
                    end
                    idx++;
                end
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        dirc  = '0;
        check("clr_x0",    32'(x0),    32'(ex[0]));
        check("clr_y0",    32'(y0),    32'(ey[0]));
        check("clr_busy0", 32'(busy0), 32'd1);
        check("clr_busy1", 32'(busy1), 32'd1);
        if (abort_at != 0) begin
            repeat (abort_at - 1) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            check_reset_state();
            repeat (3*TD) @(posedge clk);
        end else begin
            b0 = 0; b1 = 0;
            for (int k = 0; k < 70000; k++) begin
                if (busy0 !== 1'b1 && busy1 !== 1'b1) break;
                b0 += int'(busy0);
                b1 += int'(busy1);
                @(posedge clk);
                #1;
            end
            check("clr_len0", 32'(b0), 32'd65536);
            check("clr_len1", 32'(b1), 32'd65280);
            check("clr_q0_empty", 32'(q0.size()), 32'd0);
            check("clr_q1_empty", 32'(q1.size()), 32'd0);
            check("clr_x0_after", 32'(x0), 32'(ex[0]));
        end
    endtask

    initial begin
        rst = 1'b1; rgb = '0; dirc = '0; draw = 1'b0; erase = 1'b0; brush = '0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_waddr0", 32'(waddr0), 32'd0);
        check("rst_wdata0", 32'(wdata0), 32'd0);
        check_reset_state();

        move(4'b1000, 3);
        check("walk_x131", 32'(x0), 32'd131);

        move(4'b0010, 1);
        step(4'b0001, 1'b1, 1'b0, 2'd0, 12'h0F0, 0);

        move(4'b0011, 135);
        check("sat_x0", 32'(x0), 32'd0);
        check("sat_y0", 32'(y0), 32'd0);
        move(4'b1100, 10);
        move(4'b1000, 244);
        step(4'b0000, 1'b1, 1'b1, 2'd1, 12'h123, 0);

        move(4'b1010, 1);
        move(4'b0101, 1);
        move(4'b1000, 2);
        move(4'b0100, 246);
        move(4'b1100, 1);
        check("sat_x255", 32'(x0), 32'd255);
        check("sat_x254", 32'(x1), 32'd254);
        step(4'b1100, 1'b1, 1'b0, 2'd3, 12'hABC, 0);

        do_clear(0);
        move(4'b0001, 1);

        do_clear(100);
        step(4'b0000, 1'b1, 1'b0, 2'd3, 12'h555, 2);

        check("end_q0_empty", 32'(q0.size()), 32'd0);
        check("end_q1_empty", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
